// File: rtl/pi_servo_shift.sv
// Shift-gain PI servo: saturating error/integrator/sum path, conditional-integration
// anti-windup, output clamp and a rail-detect state machine.
module pi_servo_shift #(
    parameter int IN_W     = 14,
    parameter int ACC_W    = 40,
    parameter int OUT_W    = 32,
    parameter int SH_W     = 6,
    parameter int RAIL_LIM = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hold,
    input  logic                    int_clear,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  pv,
    input  logic signed [IN_W-1:0]  setpoint,
    input  logic signed [SH_W-1:0]  kp,
    input  logic signed [SH_W-1:0]  ki,
    input  logic signed [SH_W-1:0]  kg,
    input  logic                    invert,
    input  logic signed [OUT_W-1:0] out_min,
    input  logic signed [OUT_W-1:0] out_max,
    output logic signed [OUT_W-1:0] action,
    output logic                    out_valid,
    output logic [1:0]              state,
    output logic                    railed
);

    // state  | meaning
    // IDLE   | disabled; integrator and action forced to zero
    // RUN    | closed loop
    // HOLD   | integrator and action frozen, samples still flow
    // RAILED | RAIL_LIM consecutive clamped outputs seen while running
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_RAILED = 2'd3;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam int CNT_W = $clog2(RAIL_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(RAIL_LIM);

    function automatic logic signed [ACC_W-1:0] sh(input logic signed [ACC_W-1:0] x,
                                                   input logic signed [SH_W-1:0]  c);
        int n;
        logic signed [ACC_W-1:0] y;
        n = int'(c);
        if (n > ACC_W - 1) n = ACC_W - 1;
        if (n < -(ACC_W - 1)) n = -(ACC_W - 1);
        if (n >= 0) begin
            y = x <<< n;
            // any bit lost off the top shows up as a mismatch on the way back
            if ((y >>> n) != x) y = x[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end else begin
            y = x >>> (-n);
        end
        return y;
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_neg(input logic signed [ACC_W-1:0] x);
        if (x == ACC_MIN) return ACC_MAX;
        return -x;
    endfunction

    logic signed [IN_W:0]      err_r, err_d;
    logic signed [ACC_W-1:0]   err_x, integ, p_r, s_r, s_sum, s_d, a_r;
    logic signed [ACC_W-1:0]   min_x, max_x, a_clamp;
    logic                      v1, v2, v3, v4, ic1;
    logic                      rail_hi, rail_lo, a_hi, a_lo, clamped;
    logic                      err_pos, err_neg, windup, in_loop;
    logic [CNT_W-1:0]          rail_cnt, rail_cnt_d;
    logic [1:0]                state_d;

    assign err_d   = {setpoint[IN_W-1], setpoint} - {pv[IN_W-1], pv};
    assign err_x   = ACC_W'(err_r);
    assign err_pos = !err_r[IN_W] && (err_r != '0);
    assign err_neg = err_r[IN_W];
    assign windup  = (rail_hi && (err_pos ^ invert)) || (rail_lo && (err_neg ^ invert));

    assign s_sum = sat_add(p_r, sh(integ, ki));
    assign s_d   = invert ? sat_neg(s_sum) : s_sum;

    assign min_x   = ACC_W'(out_min);
    assign max_x   = ACC_W'(out_max);
    // sitting exactly on a limit counts as railed for windup and rail detect
    assign a_hi    = (a_r >= max_x);
    assign a_lo    = (a_r <= min_x);
    assign clamped = a_hi || a_lo;
    assign a_clamp = a_hi ? max_x : (a_lo ? min_x : a_r);

    assign in_loop = (state == ST_RUN) || (state == ST_RAILED);
    assign railed  = (state == ST_RAILED);

    always_comb begin
        rail_cnt_d = rail_cnt;
        if (int_clear || !in_loop) rail_cnt_d = '0;
        else if (v4) begin
            if (!clamped) rail_cnt_d = '0;
            else if (rail_cnt != CNT_LIM) rail_cnt_d = rail_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state;
        if (!en) state_d = ST_IDLE;
        else begin
            case (state)
                ST_IDLE:   state_d = ST_RUN;
                ST_RUN: begin
                    if (hold) state_d = ST_HOLD;
                    else if (rail_cnt_d == CNT_LIM) state_d = ST_RAILED;
                end
                ST_HOLD:   if (!hold) state_d = ST_RUN;
                ST_RAILED: begin
                    if (hold) state_d = ST_HOLD;
                    else if (v4 && !clamped) state_d = ST_RUN;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r     <= '0;
            ic1       <= 1'b0;
            integ     <= '0;
            p_r       <= '0;
            s_r       <= '0;
            a_r       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            v4        <= 1'b0;
            action    <= '0;
            out_valid <= 1'b0;
            rail_hi   <= 1'b0;
            rail_lo   <= 1'b0;
            rail_cnt  <= '0;
            state     <= ST_IDLE;
        end else begin
            v1  <= in_valid;
            v2  <= v1;
            v3  <= v2;
            v4  <= v3;
            ic1 <= int_clear;
            if (in_valid) err_r <= err_d;
            if (v1) p_r <= sh(err_x, kp);
            if (v2) s_r <= s_d;
            if (v3) a_r <= sh(s_r, kg);

            // a clear that arrived with the sample also zeroes it at its own update
            if (int_clear) integ <= '0;
            else if (v1) begin
                if (ic1 || state == ST_IDLE) integ <= '0;
                else if (state != ST_HOLD && !windup) integ <= sat_add(integ, err_x);
            end

            out_valid <= v4;
            if (v4) begin
                rail_hi <= a_hi;
                rail_lo <= a_lo;
                if (state == ST_IDLE) action <= '0;
                else if (state != ST_HOLD) action <= a_clamp[OUT_W-1:0];
            end

            rail_cnt <= rail_cnt_d;
            state    <= state_d;
        end
    end

endmodule

// File: tb/tb_pi_servo_shift.sv
// Scoreboard bench for pi_servo_shift: expected actions and due cycles queued at
// drive time, compared when out_valid fires; directed checks on state and integrator.
module tb_pi_servo_shift;

    localparam int IN_W     = 14;
    localparam int ACC_W    = 40;
    localparam int OUT_W    = 32;
    localparam int SH_W     = 7;
    localparam int RAIL_LIM = 4;
    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic clk = 1'b0;
    logic rst_n, en, hold, int_clear, in_valid, invert;
    logic signed [IN_W-1:0]  pv, setpoint;
    logic signed [SH_W-1:0]  kp, ki, kg;
    logic signed [OUT_W-1:0] out_min, out_max, action;
    logic                    out_valid, railed;
    logic [1:0]              state;

    typedef struct { longint val; int due; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   ov_cnt = 0;
    int   ov_before;
    longint up_tbl[10] = '{5, 10, 15, 20, 20, 20, 20, 20, 20, 20};
    // kp=-39 floors -5 to -1, so the falling phase reads integ-1
    longint dn_tbl[8]  = '{20, 20, 19, 14, 9, 4, -1, -6};

    pi_servo_shift #(
        .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W), .RAIL_LIM(RAIL_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .int_clear(int_clear),
        .in_valid(in_valid), .pv(pv), .setpoint(setpoint), .kp(kp), .ki(ki), .kg(kg),
        .invert(invert), .out_min(out_min), .out_max(out_max), .action(action),
        .out_valid(out_valid), .state(state), .railed(railed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            ov_cnt++;
            if (exp_q.size() == 0) check_val("spurious_out_valid", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check_val("action", longint'(action), mon_e.val);
                check_val("latency", longint'(cyc), longint'(mon_e.due));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input int e);
        setpoint = '0;
        pv       = IN_W'(-e);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send(input int e, input longint want);
        exp_q.push_back('{val: want, due: cyc + 5});
        send_raw(e);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            tick(1);
            t++;
        end
        check_val("drain_timeout", longint'(exp_q.size()), 0);
        exp_q.delete();
        tick(2);
    endtask

    task automatic clear_integ();
        int_clear = 1'b1;
        tick(1);
        int_clear = 1'b0;
        tick(1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; hold = 1'b0; int_clear = 1'b0; in_valid = 1'b0;
        pv = '0; setpoint = '0; kp = '0; ki = '0; kg = '0; invert = 1'b0;
        out_min = OMIN; out_max = OMAX;
        tick(3);
        check_val("rst_action", longint'(action), 0);
        check_val("rst_out_valid", longint'(out_valid), 0);
        check_val("rst_state", longint'(state), 0);
        check_val("rst_railed", longint'(railed), 0);
        check_val("rst_integ", longint'(dut.integ), 0);

        rst_n = 1'b1; en = 1'b1;
        tick(2);
        check_val("en_to_run", longint'(state), 1);

        // proportional step
        kp = SH_W'(2); ki = SH_W'(-39); kg = '0;
        for (int i = 0; i < 4; i++) send(100, 400);
        drain();

        // lower clamp
        out_min = OUT_W'(-300);
        send(-100, -300);
        drain();
        out_min = OMIN;

        // integrator ramp
        kp = SH_W'(-39); ki = '0;
        clear_integ();
        for (int i = 1; i <= 10; i++) send(5, 5 * i);
        drain();

        // anti-windup against out_max=20
        clear_integ();
        out_max = OUT_W'(20);
        for (int i = 0; i < 10; i++) send(5, up_tbl[i]);
        drain();
        check_val("windup_integ", longint'(dut.integ), 35);
        check_val("windup_railed", longint'(railed), 1);
        for (int i = 0; i < 8; i++) send(-5, dn_tbl[i]);
        drain();
        check_val("windup_exit_state", longint'(state), 1);

        // rail detect, one sample at a time
        kp = '0; ki = SH_W'(-39);
        clear_integ();
        for (int k = 1; k <= 4; k++) begin
            send(100, 20);
            drain();
            check_val("rail_railed", longint'(railed), (k == 4) ? 1 : 0);
            check_val("rail_state", longint'(state), (k == 4) ? 3 : 1);
        end
        out_max = OMAX;
        send(100, 100);
        drain();
        check_val("unrail_railed", longint'(railed), 0);
        check_val("unrail_state", longint'(state), 1);

        // invert with negative kg
        kp = SH_W'(2); kg = SH_W'(-2); invert = 1'b1;
        for (int i = 0; i < 3; i++) send(100, -100);
        drain();
        kg = '0; invert = 1'b0;

        // hold freezes integrator and action
        kp = SH_W'(-39); ki = '0;
        clear_integ();
        for (int i = 1; i <= 3; i++) begin
            send(5, 5 * i);
            drain();
        end
        hold = 1'b1;
        tick(2);
        check_val("hold_state", longint'(state), 2);
        ov_before = ov_cnt;
        for (int i = 0; i < 3; i++) begin
            send(5, 15);
            drain();
        end
        check_val("hold_pulses", longint'(ov_cnt - ov_before), 3);
        check_val("hold_integ", longint'(dut.integ), 15);
        hold = 1'b0;
        tick(2);
        check_val("unhold_state", longint'(state), 1);
        send(5, 20);
        drain();

        // en=0 mid-ramp
        en = 1'b0;
        tick(2);
        check_val("idle_state", longint'(state), 0);
        check_val("idle_railed", longint'(railed), 0);
        send(5, 0);
        drain();
        send(5, 0);
        drain();
        check_val("idle_integ", longint'(dut.integ), 0);
        check_val("idle_action", longint'(action), 0);
        en = 1'b1;
        tick(2);
        check_val("reen_state", longint'(state), 1);
        send(5, 5);
        drain();

        // reset with three samples in flight
        ov_before = ov_cnt;
        for (int i = 0; i < 3; i++) send_raw(5);
        rst_n = 1'b0;
        tick(2);
        check_val("mid_rst_action", longint'(action), 0);
        check_val("mid_rst_out_valid", longint'(out_valid), 0);
        check_val("mid_rst_state", longint'(state), 0);
        check_val("mid_rst_integ", longint'(dut.integ), 0);
        rst_n = 1'b1;
        tick(8);
        check_val("dropped_samples", longint'(ov_cnt - ov_before), 0);
        check_val("post_rst_railed", longint'(railed), 0);
        check_val("post_rst_state", longint'(state), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
